// File: rtl/mux_pkg.sv
// Shared types for the N:1 pipelined selector.
package mux_pkg;

  typedef enum logic {MODE_SEL, MODE_RR} mux_mode_t;

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: first requester at or above ptr_i, wrapping to 0.
module rr_arbiter_n #(
  parameter int NUM_CH = 4,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [SEL_W-1:0]  idx_o
);

  int  c;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    c     = 0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (int'(ptr_i) + k) % NUM_CH;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N:1 selector (explicit index or round-robin) with a one-deep registered output
// stage and valid/ready handshakes on every channel and on the output.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  localparam int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mode,
  input  logic [SEL_W-1:0]             sel,
  input  logic [NUM_CH*DATA_WIDTH-1:0] din,
  input  logic [NUM_CH-1:0]            din_valid,
  output logic [NUM_CH-1:0]            din_ready,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic [SEL_W-1:0]             dout_ch,
  output logic                         dout_valid,
  input  logic                         dout_ready
);

  mux_mode_t             mode_e;
  logic [NUM_CH-1:0]     sel_gnt, rr_gnt, grant;
  logic [SEL_W-1:0]      rr_idx, xfer_idx;
  logic                  can_load, xfer;

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [SEL_W-1:0]      ch_q, ch_d;
  logic                  vld_q, vld_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;

  assign mode_e = mux_mode_t'(mode);

  rr_arbiter_n #(.NUM_CH(NUM_CH)) u_arb (
    .req_i (din_valid),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx)
  );

  // An out-of-range sel matches no channel, so nothing is granted.
  always_comb begin
    sel_gnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) sel_gnt[i] = din_valid[i];
    end
  end

  assign grant     = (mode_e == MODE_RR) ? rr_gnt : sel_gnt;
  assign xfer_idx  = (mode_e == MODE_RR) ? rr_idx : sel;
  assign can_load  = !vld_q | dout_ready;
  assign din_ready = grant & {NUM_CH{can_load}};
  assign xfer      = |(din_ready & din_valid);

  always_comb begin
    dout_d = dout_q;
    ch_d   = ch_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    if (xfer) begin
      vld_d = 1'b1;
      ch_d  = xfer_idx;
      ptr_d = (xfer_idx == SEL_W'(NUM_CH - 1)) ? '0 : xfer_idx + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant[i]) dout_d = din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (dout_ready) begin
      vld_d = 1'b0;
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= '0;
    end else begin
      dout_q <= dout_d;
      ch_q   <= ch_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_ch    = ch_q;
  assign dout_valid = vld_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: a 4-channel instance driven from a vector table
// plus hand-written sequences, and a 3-channel instance for the out-of-range select.
module tb_mux_n_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [1:0]  sel;
  logic [63:0] din;
  logic [3:0]  din_valid;
  logic [3:0]  din_ready;
  logic [15:0] dout;
  logic [1:0]  dout_ch;
  logic        dout_valid;
  logic        dout_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [47:0] din3;
  logic [2:0]  din_valid3;
  logic [2:0]  din_ready3;
  logic [15:0] dout3;
  logic [1:0]  dout_ch3;
  logic        dout_valid3;
  logic        dout_ready3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_n_pipe #(.DATA_WIDTH(16), .NUM_CH(4)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .dout(dout),
    .dout_ch(dout_ch), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  mux_n_pipe #(.DATA_WIDTH(16), .NUM_CH(3)) dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .sel(sel3), .din(din3),
    .din_valid(din_valid3), .din_ready(din_ready3), .dout(dout3),
    .dout_ch(dout_ch3), .dout_valid(dout_valid3), .dout_ready(dout_ready3)
  );

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  vin;
    logic        rdy;
    logic [3:0]  e_rdy;
    logic [15:0] e_dout;
    logic [1:0]  e_ch;
    logic        e_vld;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  localparam logic [63:0] DIN_STD = {16'h3333, 16'hBEEF, 16'h1111, 16'h1000};

  initial begin
    reset = 1'b1; mode = 1'b0; sel = 2'd0; din = DIN_STD; din_valid = 4'b0; dout_ready = 1'b0;
    mode3 = 1'b0; sel3 = 2'd0; din3 = {16'hC222, 16'hC111, 16'hC000}; din_valid3 = 3'b0;
    dout_ready3 = 1'b1;

    // mode, sel, valid, dout_ready | din_ready, dout, dout_ch, dout_valid after the edge
    tbl[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 16'hBEEF, 2'd2, 1'b1};
    tbl[1]  = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000, 16'hBEEF, 2'd2, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0001, 16'h1000, 2'd0, 1'b1};
    tbl[3]  = '{1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, 16'h1000, 2'd0, 1'b1};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 16'h1111, 2'd1, 1'b1};
    tbl[5]  = '{1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 16'h1000, 2'd0, 1'b1};
    tbl[6]  = '{1'b1, 2'd0, 4'b1100, 1'b1, 4'b0100, 16'hBEEF, 2'd2, 1'b1};
    tbl[7]  = '{1'b1, 2'd0, 4'b0101, 1'b1, 4'b0001, 16'h1000, 2'd0, 1'b1};
    tbl[8]  = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 16'h3333, 2'd3, 1'b1};
    tbl[9]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 16'h1000, 2'd0, 1'b1};
    tbl[10] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 16'h1000, 2'd0, 1'b0};

    #2;
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_ch", 32'(dout_ch), 32'h0);
    check("reset_vld", 32'(dout_valid), 32'h0);
    tick();
    reset = 1'b0;
    #1;

    for (int i = 0; i < 11; i++) begin
      mode = tbl[i].mode; sel = tbl[i].sel; din_valid = tbl[i].vin; dout_ready = tbl[i].rdy;
      #1;
      check($sformatf("tbl%0d_din_ready", i), 32'(din_ready), 32'(tbl[i].e_rdy));
      tick();
      check($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].e_dout));
      check($sformatf("tbl%0d_ch", i), 32'(dout_ch), 32'(tbl[i].e_ch));
      check($sformatf("tbl%0d_vld", i), 32'(dout_valid), 32'(tbl[i].e_vld));
    end

    // Round-robin streaming, all channels valid, no bubbles.
    din_valid = 4'b0; do_reset();
    mode = 1'b1; din_valid = 4'b1111; dout_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [15:0] exp_w;
      exp_w = DIN_STD[(k % 4)*16 +: 16];
      tick();
      check($sformatf("rr%0d_ch", k), 32'(dout_ch), 32'(k % 4));
      check($sformatf("rr%0d_dout", k), 32'(dout), 32'(exp_w));
      check($sformatf("rr%0d_vld", k), 32'(dout_valid), 32'h1);
    end

    // Backpressure: hold channel 1's word while channel 3 waits.
    din_valid = 4'b0; do_reset();
    din = {16'h3333, 16'hBEEF, 16'h1234, 16'h1000};
    mode = 1'b0; sel = 2'd1; din_valid = 4'b0010; dout_ready = 1'b1;
    tick();
    check("bp_load", 32'(dout), 32'h1234);
    mode = 1'b1; din_valid = 4'b1000; dout_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_din_ready", k), 32'(din_ready), 32'h0);
      tick();
      check($sformatf("bp%0d_dout", k), 32'(dout), 32'h1234);
      check($sformatf("bp%0d_vld", k), 32'(dout_valid), 32'h1);
    end
    dout_ready = 1'b1;
    #1;
    check("bp_release_din_ready", 32'(din_ready), 32'b1000);
    tick();
    check("bp_release_dout", 32'(dout), 32'h3333);
    check("bp_release_ch", 32'(dout_ch), 32'd3);
    check("bp_release_vld", 32'(dout_valid), 32'h1);
    din = DIN_STD;

    // Three-channel instance: load once, then an out-of-range select drains it.
    din_valid3 = 3'b111; sel3 = 2'd0;
    tick();
    check("n3_load_vld", 32'(dout_valid3), 32'h1);
    check("n3_load_dout", 32'(dout3), 32'hC000);
    sel3 = 2'd3;
    #1;
    check("n3_oor_din_ready", 32'(din_ready3), 32'h0);
    tick();
    check("n3_oor_vld", 32'(dout_valid3), 32'h0);
    tick();
    check("n3_oor_vld2", 32'(dout_valid3), 32'h0);
    check("n3_oor_din_ready2", 32'(din_ready3), 32'h0);

    // Reset mid-stream clears the held word asynchronously; rr_ptr restarts at 0.
    mode = 1'b1; din_valid = 4'b1111; dout_ready = 1'b1;
    tick(); tick();
    check("mid_pre_vld", 32'(dout_valid), 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_vld", 32'(dout_valid), 32'h0);
    check("mid_rst_dout", 32'(dout), 32'h0);
    check("mid_rst_ch", 32'(dout_ch), 32'h0);
    #1;
    reset = 1'b0;
    din_valid = 4'b0101;
    #1;
    check("mid_post_din_ready", 32'(din_ready), 32'b0001);
    tick();
    check("mid_post_ch", 32'(dout_ch), 32'd0);
    check("mid_post_dout", 32'(dout), 32'h1000);
    check("mid_post_vld", 32'(dout_valid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised N:1 data selector with a one-deep registered output stage and per-channel valid/ready handshakes. It selects one of `NUM_CH` input channels, either by an explicit select index or by round-robin arbitration, and presents the chosen word one cycle later. It sits between multiple producers (register-file read ports, immediate/ALU/memory result paths) and a single consumer stage in the datapath, and generalises the plain 2:1 combinational mux used there.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of each data word.
- `NUM_CH`, 4, number of input channels; legal range is 2 or more, power of two not required.
- `SEL_W`, `$clog2(NUM_CH)`, derived localparam; width of the select index and channel tag.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mode`  in  1  0 = explicit select (`MODE_SEL`), 1 = round-robin (`MODE_RR`).
- `sel`  in  SEL_W  channel index, used only in `MODE_SEL`.
- `din`  in  NUM_CH×DATA_WIDTH  packed input words; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `din_valid`  in  NUM_CH  per-channel valid.
- `din_ready`  out  NUM_CH  per-channel ready; at most one bit is high in any cycle.
- `dout`  out  DATA_WIDTH  registered selected word.
- `dout_ch`  out  SEL_W  index of the channel that produced `dout`.
- `dout_valid`  out  1  output register holds valid data.
- `dout_ready`  in  1  consumer accepts `dout` this cycle.

## Operation
- State consists of the output register (`dout`, `dout_ch`, `dout_valid`) and the round-robin pointer `rr_ptr` (SEL_W bits).
- `can_load = !dout_valid | dout_ready`.
- Grant is combinational and one-hot or zero:
  - In `MODE_SEL`, channel `sel` is granted if `din_valid[sel]` is high. If `sel >= NUM_CH`, no channel is granted.
  - In `MODE_RR`, the granted channel is the first i with `din_valid[i]`, searching from `rr_ptr` upward and wrapping from NUM_CH-1 to 0.
- `din_ready[i] = grant[i] & can_load`. A transfer occurs on channel i when `din_valid[i] & din_ready[i]`.
- On a transfer:
  - `dout <= din[i]`, `dout_ch <= i`, `dout_valid <= 1`.
  - `rr_ptr <= (i == NUM_CH-1) ? 0 : i+1`. This update happens in both modes.
- If `dout_valid & dout_ready` and there is no transfer, then `dout_valid <= 0`. `dout` and `dout_ch` keep their value.
- Stall (`dout_valid & !dout_ready`): `dout` and `dout_ch` are held stable, and every `din_ready` bit is 0.
- A `mode` or `sel` change affects only grants made in the same cycle. Data already held in the output register is never altered.

## Timing
- Reset values (asynchronous, take effect immediately): `dout` = 0, `dout_ch` = 0, `dout_valid` = 0, `rr_ptr` = 0. `din_ready` is combinational and reads 0 only when there is no grant.
- Latency is 1 cycle from input transfer to `dout_valid`.
- Throughput is 1 word per cycle when `dout_ready` is held high. Drain and refill in the same cycle is supported with no bubble.
- Handshake rules:
  - A producer must hold `din` stable while `din_valid` is high and `din_ready` is low.
  - `din_ready` may depend on `din_valid`, `mode`, `sel` and `dout_ready` (combinational path).
- Reset asserted mid-stream: the held word is discarded and `dout_valid` drops asynchronously. No transfer completes in a cycle where `reset` is high.

## Structure
- Package `mux_pkg` holds:
  - `typedef enum logic {MODE_SEL, MODE_RR} mux_mode_t`.
  - No width constants; widths stay per-instance parameters.
- Sub-module `rr_arbiter_n` (parameter `NUM_CH`): inputs are a request vector and `rr_ptr`; outputs are the one-hot grant and the encoded index. It is purely combinational.
- `mux_n_pipe` holds all state, the mode mux between the explicit and arbitrated grants, and the output register.

## Test plan
- Reset, then `MODE_SEL`, `sel=2`, `din_valid=4'b0100`, `din[2]=16'hBEEF`, `dout_ready=1`: one cycle later `dout=16'hBEEF`, `dout_ch=2`, `dout_valid=1`. `din_ready` equals 4'b0100 during the transfer cycle.
- `MODE_RR`, all four channels valid continuously, `dout_ready=1`: `dout_ch` sequence is 0,1,2,3,0,… with one word per cycle and no bubbles.
- Backpressure: load channel 1 = 16'h1234, hold `dout_ready=0` for 3 cycles with channel 3 valid. `dout` stays 16'h1234, `din_ready=0`. On release, channel 3's word appears the next cycle with no gap.
- `MODE_SEL` with `NUM_CH=3` and `sel=3`, all channels valid: `din_ready=0` and `dout_valid` stays 0 after draining.
- Assert `reset` mid-stream while `dout_valid=1`: `dout_valid`, `dout` and `dout_ch` go to 0 before the next edge. After release in `MODE_RR` with channels 2 and 0 valid, the first grant is channel 0 (`rr_ptr` = 0).
